// File: rtl/bcd_serial_subtractor.sv
// ============================================================================
// Module   : bcd_serial_subtractor
// Brief    : Digit-serial packed-BCD subtractor, one digit per clock, LSD first.
//            Optional invalid-digit flag enabled by BCD_DIGIT_CHECK_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bcd_serial_subtractor #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   minuend,
    input  logic [4*DIGITS-1:0]   subtrahend,
    input  logic                  borrow_in,
    output logic [4*DIGITS-1:0]   difference,
    output logic                  borrow_out,
    output logic                  busy,
    output logic                  done,
    output logic                  digit_err
);

    localparam int c_w     = 4 * DIGITS;
    localparam int c_cnt_w = $clog2(DIGITS);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_w-1:0]      r_a;
    logic [c_w-1:0]      r_b;
    logic                r_brw;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_w-1:0]      r_diff;
    logic                r_borrow_out;

    logic                w_accept;
    logic                w_last;
    logic [4:0]          w_t;
    logic [3:0]          w_digit;
    logic                w_brw_nxt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (start) w_next = ST_RUN;
            ST_RUN:  if (w_last) w_next = ST_DONE;
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_cnt == c_last);

    // Operands shift right each cycle so the active digit is always at [3:0].
    always_comb begin
        w_t       = {1'b0, r_a[3:0]} - {1'b0, r_b[3:0]} - {4'b0000, r_brw};
        w_brw_nxt = w_t[4];
        w_digit   = w_t[4] ? (w_t[3:0] + 4'd10) : w_t[3:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a          <= '0;
            r_b          <= '0;
            r_brw        <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a    <= minuend;
            r_b    <= subtrahend;
            r_brw  <= borrow_in;
            r_diff <= '0;
            r_cnt  <= '0;
        end else if (r_state == ST_RUN) begin
            r_diff[{r_cnt, 2'b00} +: 4] <= w_digit;
            r_a   <= {4'h0, r_a[c_w-1:4]};
            r_b   <= {4'h0, r_b[c_w-1:4]};
            r_brw <= w_brw_nxt;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                r_borrow_out <= w_brw_nxt;
            end
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    logic r_err_sticky;
    logic r_digit_err;
    logic w_bad;
    logic w_sticky_nxt;

    assign w_bad        = (r_a[3:0] > 4'd9) || (r_b[3:0] > 4'd9);
    assign w_sticky_nxt = r_err_sticky | w_bad;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_sticky <= 1'b0;
            r_digit_err  <= 1'b0;
        end else if (w_accept) begin
            r_err_sticky <= 1'b0;
            r_digit_err  <= 1'b0;
        end else if (r_state == ST_RUN) begin
            r_err_sticky <= w_sticky_nxt;
            if (w_last) begin
                r_digit_err <= w_sticky_nxt;
            end
        end
    end

    assign digit_err = r_digit_err;
`else
    assign digit_err = 1'b0;
`endif

    assign difference = r_diff;
    assign borrow_out = r_borrow_out;
    assign busy       = (r_state != ST_IDLE);
    assign done       = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_bcd_serial_subtractor.sv
// ============================================================================
// Module   : tb_bcd_serial_subtractor
// Brief    : Scoreboard bench for bcd_serial_subtractor against a decimal model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bcd_serial_subtractor;

    localparam int D = 4;
    localparam int W = 4 * D;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         e;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] minuend;
    logic [W-1:0] subtrahend;
    logic         borrow_in;
    logic [W-1:0] difference;
    logic         borrow_out;
    logic         busy;
    logic         done;
    logic         digit_err;

    exp_t exp_q[$];
    int   checks     = 0;
    int   errors     = 0;
    int   done_count = 0;
    int   cyc        = 0;

    bcd_serial_subtractor #(.DIGITS(D)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .minuend    (minuend),
        .subtrahend (subtrahend),
        .borrow_in  (borrow_in),
        .difference (difference),
        .borrow_out (borrow_out),
        .busy       (busy),
        .done       (done),
        .digit_err  (digit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic longint bcd2int(input logic [W-1:0] x);
        longint v = 0;
        longint p = 1;
        for (int i = 0; i < D; i++) begin
            v = v + longint'(x[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    function automatic logic [W-1:0] int2bcd(input longint v);
        logic [W-1:0] x = '0;
        for (int i = 0; i < D; i++) begin
            x[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return x;
    endfunction

    function automatic logic [W-1:0] rand_bcd();
        logic [W-1:0] x;
        for (int i = 0; i < D; i++) x[4*i +: 4] = 4'($urandom_range(0, 9));
        return x;
    endfunction

    // Decimal reference: subtract as integers, wrap negatives to ten's complement.
    function automatic exp_t model(input logic [W-1:0] m, input logic [W-1:0] s, input logic b);
        exp_t   e;
        longint modulus = 1;
        longint v;
        for (int i = 0; i < D; i++) modulus = modulus * 10;
        v   = bcd2int(m) - bcd2int(s) - longint'(b);
        e.b = (v < 0);
        if (v < 0) v = v + modulus;
        e.d = int2bcd(v);
        e.e = 1'b0;
        return e;
    endfunction

    // Monitor: every done pulse pops one expected result.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                check("sb_has_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("difference", 64'(difference), 64'(e.d));
                    check("borrow_out", 64'(borrow_out), 64'(e.b));
                    check("digit_err",  64'(digit_err),  64'(e.e));
                    check("busy_at_done", 64'(busy), 64'd1);
                end
            end
        end
    end

    task automatic issue(input logic [W-1:0] m, input logic [W-1:0] s, input logic b,
                         input exp_t e, input bit push);
        @(negedge clk);
        minuend    = m;
        subtrahend = s;
        borrow_in  = b;
        start      = 1'b1;
        if (push) exp_q.push_back(e);
        @(negedge clk);
        start      = 1'b0;
        minuend    = rand_bcd();
        subtrahend = rand_bcd();
        borrow_in  = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_within_bound", 64'(n < 100), 64'd1);
    endtask

    task automatic run_op(input logic [W-1:0] m, input logic [W-1:0] s, input logic b, input exp_t e);
        int n;
        issue(m, s, b, e, 1'b1);
        wait_done(n);
        check("latency", 64'(n), 64'(D));
        @(negedge clk);
        check("busy_after", 64'(busy), 64'd0);
        check("done_one_cycle", 64'(done), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   base;
        int   k;
        int   guard;
        int   t[3];
        exp_t e;
        logic [W-1:0] m;
        logic [W-1:0] s;
        logic         b;

        rst_n      = 1'b0;
        start      = 1'b0;
        minuend    = 16'h1234;
        subtrahend = 16'h5678;
        borrow_in  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_difference", 64'(difference), 64'd0);
        check("rst_borrow_out", 64'(borrow_out), 64'd0);
        check("rst_busy",       64'(busy),       64'd0);
        check("rst_done",       64'(done),       64'd0);
        check("rst_digit_err",  64'(digit_err),  64'd0);
        rst_n = 1'b1;

        run_op(16'h0042, 16'h0017, 1'b0, model(16'h0042, 16'h0017, 1'b0));
        run_op(16'h0000, 16'h0001, 1'b0, model(16'h0000, 16'h0001, 1'b0));
        run_op(16'h9999, 16'h9999, 1'b1, model(16'h9999, 16'h9999, 1'b1));

        // A start pulse while busy must be ignored.
        base = done_count;
        issue(16'h5000, 16'h0001, 1'b0, model(16'h5000, 16'h0001, 1'b0), 1'b1);
        @(negedge clk);
        minuend    = 16'h7777;
        subtrahend = 16'h1111;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
        wait_done(n);
        repeat (10) @(negedge clk);
        check("busy_start_ignored", 64'(done_count - base), 64'd1);

        // start held high: back-to-back operations.
        @(negedge clk);
        minuend    = 16'h1234;
        subtrahend = 16'h1234;
        borrow_in  = 1'b0;
        start      = 1'b1;
        for (int i = 0; i < 3; i++) exp_q.push_back(model(16'h1234, 16'h1234, 1'b0));
        k     = 0;
        guard = 0;
        while (k < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (done === 1'b1) begin
                t[k] = cyc;
                k++;
                if (k == 3) start = 1'b0;
            end
        end
        check("hold_done_count", 64'(k), 64'd3);
        check("hold_spacing_0", 64'(t[1] - t[0]), 64'(D + 2));
        check("hold_spacing_1", 64'(t[2] - t[1]), 64'(D + 2));
        repeat (10) @(negedge clk);

        // Reset while digit 2 is being processed discards the operation.
        base = done_count;
        issue(16'h8642, 16'h1357, 1'b0, e, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midrst_difference", 64'(difference), 64'd0);
        check("midrst_borrow_out", 64'(borrow_out), 64'd0);
        check("midrst_busy",       64'(busy),       64'd0);
        check("midrst_done",       64'(done),       64'd0);
        check("midrst_digit_err",  64'(digit_err),  64'd0);
        repeat (12) @(negedge clk);
        check("midrst_no_done", 64'(done_count - base), 64'd0);
        run_op(16'h0500, 16'h0499, 1'b0, model(16'h0500, 16'h0499, 1'b0));

        // Invalid digit A in the tens position of the minuend.
        e.d = 16'h0099;
        e.b = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        e.e = 1'b1;
`else
        e.e = 1'b0;
`endif
        run_op(16'h00A0, 16'h0001, 1'b0, e);
        run_op(16'h0100, 16'h0001, 1'b0, model(16'h0100, 16'h0001, 1'b0));

        for (int i = 0; i < 20; i++) begin
            m = rand_bcd();
            s = rand_bcd();
            b = 1'($urandom_range(0, 1));
            run_op(m, s, b, model(m, s, b));
        end

        repeat (5) @(negedge clk);
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
